// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one multi-cycle main memory between the I-cache miss path and the
// D-cache miss / write-through path. Performs BLOCK_WORDS-word block fills for
// either side and single-word write-throughs for the D side. Returned words are
// streamed to the owning cache as they arrive; completion is signalled with a
// registered one-cycle done pulse. D has fixed priority over I.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   i_req, i_addr         I-side fill request (held until i_done) and address
//   d_req, d_we, d_addr,  D-side request (held until d_done), write-through
//   d_wdata               select, address and write data
//   i_busy, d_busy        arbiter is serving that side
//   i_fill_valid,         fill_data/fill_idx carry a valid word for that side
//   d_fill_valid
//   fill_idx, fill_data   word index within the block and the returned word
//   i_done, d_done        one-cycle completion pulses
//   mem_en, mem_wr,       memory command: enable, write, byte address, data
//   mem_addr, mem_wdata
//   mem_rdata, mem_rvalid read data, valid exactly LATENCY cycles after a read
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int LATENCY     = 4,
  parameter int BLOCK_WORDS = 8,
  localparam int IDX_W      = $clog2(BLOCK_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [15:0]      i_addr,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [15:0]      d_addr,
  input  logic [15:0]      d_wdata,
  output logic             i_busy,
  output logic             d_busy,
  output logic             i_fill_valid,
  output logic             d_fill_valid,
  output logic [IDX_W-1:0] fill_idx,
  output logic [15:0]      fill_data,
  output logic             i_done,
  output logic             d_done,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_rvalid
);

  localparam int CNT_W = IDX_W + 1;              // counts 0..BLOCK_WORDS
  localparam int OFF_W = IDX_W + 1;              // byte-offset bits within a block
  localparam int DRN_W = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {
    DRAIN   = 3'd0,
    IDLE    = 3'd1,
    I_FILL  = 3'd2,
    D_FILL  = 3'd3,
    D_WRITE = 3'd4
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [DRN_W-1:0]   drain_cnt_r;
  logic [CNT_W-1:0]   issue_cnt_r;
  logic [CNT_W-1:0]   recv_cnt_r;
  logic [15:0]        addr_r;        // block base for fills, exact address for writes
  logic [15:0]        wdata_r;
  logic               i_done_r, d_done_r;

  logic               in_fill_s;
  logic               issue_s;
  logic               rvalid_fill_s;
  logic               fill_last_s;
  logic               drain_last_s;
  logic               grant_d_s, grant_i_s;

  // Aligns a byte address down to the start of its cache block.
  function automatic logic [15:0] block_base(input logic [15:0] a);
    block_base = {a[15:OFF_W], {OFF_W{1'b0}}};
  endfunction

  assign in_fill_s     = (state_r == I_FILL) || (state_r == D_FILL);
  assign issue_s       = in_fill_s && (issue_cnt_r < CNT_W'(BLOCK_WORDS));
  // Read data is only accepted inside a fill; anything else (e.g. reads
  // in flight across a reset) is dropped.
  assign rvalid_fill_s = in_fill_s && mem_rvalid;
  assign fill_last_s   = rvalid_fill_s && (recv_cnt_r == CNT_W'(BLOCK_WORDS - 1));
  assign drain_last_s  = (drain_cnt_r == DRN_W'(LATENCY - 1));

  // Next-state and grant decode; a side whose done pulse is high this cycle is
  // masked so a still-held request is not re-granted immediately.
  always_comb begin
    state_nxt_s = state_r;
    grant_d_s   = 1'b0;
    grant_i_s   = 1'b0;
    case (state_r)
      DRAIN: begin
        if (drain_last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      IDLE: begin
        if (d_req && !d_done_r) begin
          grant_d_s = 1'b1;
          if (d_we) begin
            state_nxt_s = D_WRITE;
          end else begin
            state_nxt_s = D_FILL;
          end
        end else if (i_req && !i_done_r) begin
          grant_i_s   = 1'b1;
          state_nxt_s = I_FILL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      I_FILL, D_FILL: begin
        if (fill_last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      D_WRITE: state_nxt_s = IDLE;
      default: state_nxt_s = DRAIN;
    endcase
  end

  // State register, counters, captured request and registered done pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= DRAIN;
      drain_cnt_r <= '0;
      issue_cnt_r <= '0;
      recv_cnt_r  <= '0;
      addr_r      <= 16'h0000;
      wdata_r     <= 16'h0000;
      i_done_r    <= 1'b0;
      d_done_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      i_done_r <= (state_r == I_FILL) && fill_last_s;
      d_done_r <= ((state_r == D_FILL) && fill_last_s) || (state_r == D_WRITE);

      if ((state_r == DRAIN) && !drain_last_s) begin
        drain_cnt_r <= drain_cnt_r + DRN_W'(1);
      end else begin
        drain_cnt_r <= '0;
      end

      if (state_r == IDLE) begin
        issue_cnt_r <= '0;
        recv_cnt_r  <= '0;
        if (grant_d_s) begin
          addr_r  <= d_we ? d_addr : block_base(d_addr);
          wdata_r <= d_wdata;
        end else if (grant_i_s) begin
          addr_r  <= block_base(i_addr);
        end
      end else begin
        if (issue_s) begin
          issue_cnt_r <= issue_cnt_r + CNT_W'(1);
        end
        if (rvalid_fill_s) begin
          recv_cnt_r <= recv_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  // Output decode; everything is forced to 0 while rst_n is low so the
  // interface is quiet in the reset cycle itself, and DRAIN decodes to 0.
  always_comb begin
    i_busy       = 1'b0;
    d_busy       = 1'b0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    fill_idx     = '0;
    fill_data    = 16'h0000;
    i_done       = 1'b0;
    d_done       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    if (rst_n) begin
      i_done = i_done_r;
      d_done = d_done_r;
      case (state_r)
        I_FILL, D_FILL: begin
          i_busy = (state_r == I_FILL);
          d_busy = (state_r == D_FILL);
          if (issue_s) begin
            mem_en   = 1'b1;
            mem_addr = addr_r + 16'({issue_cnt_r, 1'b0});
          end else begin
            mem_en   = 1'b0;
          end
          if (mem_rvalid) begin
            i_fill_valid = (state_r == I_FILL);
            d_fill_valid = (state_r == D_FILL);
            fill_idx     = recv_cnt_r[IDX_W-1:0];
            fill_data    = mem_rdata;
          end else begin
            fill_data    = 16'h0000;
          end
        end
        D_WRITE: begin
          d_busy    = 1'b1;
          mem_en    = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = addr_r;
          mem_wdata = wdata_r;
        end
        default: begin
          mem_en = 1'b0;
        end
      endcase
    end else begin
      mem_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A small memory model returns word
// (addr ^ 16'h5A5A) exactly LATENCY cycles after each read command.
// Inputs change 1 time unit after the rising edge; outputs are compared
// 2 time units after the edge, once combinational outputs have settled.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_busy, d_busy, i_fill_valid, d_fill_valid, i_done, d_done;
  logic [2:0]  fill_idx;
  logic [15:0] fill_data;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic        pv [LAT];
  logic [15:0] pa [LAT];

  mem_arbiter #(.LATENCY(LAT), .BLOCK_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_busy(i_busy), .d_busy(d_busy),
    .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .fill_idx(fill_idx), .fill_data(fill_data),
    .i_done(i_done), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    mdata = a ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Every DUT output packed together; used for "all quiet" checks.
  function automatic logic [63:0] all_outs();
    all_outs = {5'd0, i_busy, d_busy, i_fill_valid, d_fill_valid, i_done, d_done,
                mem_en, mem_wr, fill_idx, mem_addr, mem_wdata, fill_data};
  endfunction

  // Record this cycle's read, advance one clock, present returned data.
  task automatic step();
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = mem_en && !mem_wr;
    pa[0] = mem_addr;
    @(posedge clk);
    #1;
    cyc++;
    mem_rvalid = pv[LAT-1];
    mem_rdata  = pv[LAT-1] ? mdata(pa[LAT-1]) : 16'h0000;
    #1;
  endtask

  // Called in the first fill cycle T; walks T..T+11 and checks the done cycle.
  task automatic fill_walk(input bit is_d, input logic [15:0] base);
    logic fv;
    logic [7:0] ctl_exp;
    for (int c = 0; c < 12; c++) begin
      fv      = (c >= 4);
      ctl_exp = {~is_d, is_d, ~is_d & fv, is_d & fv, 1'b0, 1'b0, (c < 8), 1'b0};
      chk("fill_ctl", 64'({i_busy, d_busy, i_fill_valid, d_fill_valid,
                           i_done, d_done, mem_en, mem_wr}), 64'(ctl_exp));
      if (c < 8) begin
        chk("fill_addr", 64'(mem_addr), 64'(base + 16'(2 * c)));
      end
      if (fv) begin
        chk("fill_idx", 64'(fill_idx), 64'(c - 4));
        chk("fill_data", 64'(fill_data), 64'(mdata(base + 16'(2 * (c - 4)))));
      end
      step();
    end
    chk("done_pulse", 64'({i_busy, d_busy, i_done, d_done}),
        64'({2'b00, ~is_d, is_d}));
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pa[i] = 16'h0000;
    end
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
    mem_rvalid = 1'b0; mem_rdata = 16'h0000;
    #1;
    step();
    step();
    chk("reset_outs", all_outs(), 64'd0);

    // Release reset; request I immediately: only granted after 4 DRAIN cycles.
    rst_n  = 1'b1;
    i_req  = 1'b1;
    i_addr = 16'h1236;
    #1;
    chk("drain0_outs", all_outs(), 64'd0);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("drain_outs", all_outs(), 64'd0);
    end
    step();                                  // IDLE, request seen
    chk("idle_busy", 64'({i_busy, d_busy, mem_en}), 64'd0);
    step();                                  // I_FILL cycle T
    fill_walk(1'b0, 16'h1230);
    i_req = 1'b0;
    step();
    chk("i_done_one_cycle", 64'({i_done, i_busy, d_busy}), 64'd0);

    // Simultaneous requests: D fill first, then I right after d_done.
    i_req  = 1'b1; i_addr = 16'h2468;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 16'h4000;
    step();
    fill_walk(1'b1, 16'h4000);
    d_req = 1'b0;
    step();                                  // I_FILL entered after d_done
    fill_walk(1'b0, 16'h2460);
    i_req = 1'b0;
    step();

    // Write-through, held one cycle past d_done, then re-granted.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0102; d_wdata = 16'hBEEF;
    step();
    chk("wr_cmd", 64'({d_busy, i_busy, mem_en, mem_wr, d_done}), 64'(5'b10110));
    chk("wr_addr", 64'(mem_addr), 64'h0102);
    chk("wr_data", 64'(mem_wdata), 64'hBEEF);
    step();
    chk("wr_done", 64'({d_done, d_busy, mem_en}), 64'(3'b100));
    step();                                  // d_req still high: masked last cycle
    chk("held_no_regrant", 64'({d_busy, mem_en, d_done}), 64'd0);
    step();                                  // still high -> granted again
    chk("held_regrant", 64'({d_busy, mem_en, mem_wr}), 64'(3'b111));
    d_req = 1'b0;
    step();
    chk("regrant_done", 64'(d_done), 64'd1);
    step();

    // Stray read data while idle must not reach either cache.
    mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    chk("stray_rvalid", 64'({i_fill_valid, d_fill_valid, fill_data}), 64'd0);

    // Fill at the top of the address space: no wrap past 0xFFFE.
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'hFFFA;
    step();
    fill_walk(1'b1, 16'hFFF0);
    d_req = 1'b0;
    step();

    // Reset during fill cycle 5; stale returns must be discarded.
    i_req = 1'b1; i_addr = 16'h8000;
    step();                                  // T
    for (int k = 0; k < 5; k++) begin
      step();
    end
    rst_n = 1'b0;
    i_req = 1'b0;
    #1;
    chk("midreset_outs", all_outs(), 64'd0);
    step();                                  // DRAIN cnt0
    rst_n  = 1'b1;
    i_req  = 1'b1;
    i_addr = 16'h1236;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("stale_drain_outs", all_outs(), 64'd0);
      step();
    end
    chk("post_drain_idle", 64'({i_busy, i_done, i_fill_valid}), 64'd0);
    step();
    fill_walk(1'b0, 16'h1230);
    i_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the single shared, multi-cycle main memory between the instruction-cache miss path and the data-cache miss/write-through path of the pipelined CPU. It performs 8-word block fills for either cache and single-word write-throughs for the data side. It streams returned words to the owning cache and signals completion with a one-cycle done pulse. It sits between the two cache controllers and the memory model, inside `cpu`.

## Interface
Parameters:
- `LATENCY`, 4, memory read latency in cycles, mem_en to mem_rvalid
- `BLOCK_WORDS`, 8, 16-bit words per cache block (power of 2)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `i_req`  in  1  I-cache miss request; held until `i_done`
- `i_addr`  in  16  I-side miss byte address
- `d_req`  in  1  D-side request; held until `d_done`
- `d_we`  in  1  D-side request is a write-through (1) or a block fill (0)
- `d_addr`  in  16  D-side byte address
- `d_wdata`  in  16  D-side write data
- `i_busy`, `d_busy`  out  1  arbiter is currently serving that side
- `i_fill_valid`, `d_fill_valid`  out  1  `fill_data` is a valid word for that side this cycle
- `fill_idx`  out  3  word index within block of `fill_data`
- `fill_data`  out  16  returned memory word
- `i_done`, `d_done`  out  1  one-cycle pulse: transaction complete
- `mem_en`  out  1  memory access this cycle
- `mem_wr`  out  1  access is a write
- `mem_addr`  out  16  memory byte address
- `mem_wdata`  out  16  memory write data
- `mem_rdata`  in  16  memory read data
- `mem_rvalid`  in  1  `mem_rdata` valid; returns exactly LATENCY cycles after a read `mem_en`

## Operation
- States: `DRAIN`, `IDLE`, `I_FILL`, `D_FILL`, `D_WRITE`.
- Reset (`rst_n`=0 at an edge) enters `DRAIN` and clears all counters. Every output is 0 while in reset and in `DRAIN`.
- `DRAIN` lasts LATENCY cycles, then the FSM moves to `IDLE`. No request is granted and `mem_rvalid` is ignored, so reads in flight before reset are discarded.
- Arbitration in `IDLE`, evaluated in the current cycle:
  - If `d_req`=1 and the D side is not masked: go to `D_WRITE` if `d_we`=1, otherwise `D_FILL`.
  - Else if `i_req`=1 and the I side is not masked: go to `I_FILL`.
  - D has fixed priority over I. I cannot starve, because a D miss stalls the pipeline, so D requests stop until the pipeline advances.
- Mask: during the cycle its done pulse is high, the side just served is ignored by arbitration. The other side may be granted in that same cycle.
- Fill behaviour:
  - base = addr with bits [3:0] cleared.
  - Issue counter k=0..7: `mem_en`=1, `mem_wr`=0, `mem_addr`=base+2k, on 8 consecutive cycles.
  - Receive counter r counts `mem_rvalid` pulses.
  - Each `mem_rvalid` in a fill state drives the owner's `fill_valid`=1, `fill_data`=`mem_rdata` and `fill_idx`=r, combinationally in the same cycle.
  - After r reaches 8, the FSM goes to `IDLE` and the registered done pulse for the owner is asserted for exactly one cycle.
- Write-through: one cycle with `mem_en`=1, `mem_wr`=1, `mem_addr`=`d_addr` (unaligned bit 0 passed through), `mem_wdata`=`d_wdata`. Then the FSM returns to `IDLE` with `d_done`=1.
- `busy` for a side is high in that side's active state only.
- A requester dropping its request before done is illegal. The transaction completes regardless.
- `mem_rvalid` outside a fill state is ignored. `fill_valid` stays 0.
- Address arithmetic is 16-bit modulo. Base 0xFFF0 issues addresses 0xFFF0..0xFFFE with no wrap into the next block.

## Timing
- Request high in `IDLE` cycle T-1 → fill state in cycle T. `mem_en` is high in T..T+7. `mem_rvalid` and `fill_valid` are high in T+4..T+11 (LATENCY=4). Done is high in T+12, while the FSM is in `IDLE`.
- Fill occupancy is 12 cycles. Total request-to-done latency is BLOCK_WORDS+LATENCY+1 = 13 cycles.
- Write-through: request in T-1 → `D_WRITE` in T → `d_done` in T+1. Request-to-done latency is 2 cycles.
- Back-to-back grants: a new transaction can enter its state in the cycle after a done pulse. A pending other-side request is granted from the done cycle itself.
- Reset mid-fill: the FSM is in `DRAIN` the cycle after the reset edge. No done pulse is produced, and no stale `fill_valid` appears for LATENCY cycles after reset.
- Outputs at reset: `i_busy`=`d_busy`=`i_done`=`d_done`=`i_fill_valid`=`d_fill_valid`=`mem_en`=`mem_wr`=0, `mem_addr`=`mem_wdata`=`fill_data`=0x0000, `fill_idx`=0.

## Test plan
- I fill: `i_addr`=0x1236 → `mem_addr` 0x1230,0x1232,…,0x123E on 8 consecutive cycles. `i_fill_valid` is high with `fill_idx` 0..7. `i_done` arrives 13 cycles after the request and lasts 1 cycle. The D-side outputs stay 0.
- Simultaneous requests: `i_req` and `d_req` (`d_we`=0, `d_addr`=0x4000) high in the same cycle → the D fill runs first. `d_done`, then `I_FILL` is entered in the cycle after the `d_done` cycle. `i_done` comes 13 cycles after `d_done`.
- Write-through: `d_we`=1, `d_addr`=0x0102, `d_wdata`=0xBEEF → one cycle of `mem_en`=1, `mem_wr`=1 with 0x0102/0xBEEF. `d_done` follows on the next cycle.
- Held request after done: the D requester keeps `d_req` high for 1 cycle after `d_done` → no second grant. The request is re-granted only if it is still high on the following cycle.
- Reset mid-fill: assert `rst_n`=0 for 1 cycle at fill cycle 5 → outputs 0. Late `mem_rvalid` pulses produce no `fill_valid`. An `i_req` raised immediately after reset is granted only after 4 `DRAIN` cycles.
- Wrap boundary: `d_addr`=0xFFFA fill → `mem_addr` 0xFFF0..0xFFFE. `fill_idx` 0..7 and `d_done` are asserted normally.
